mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_arbiter2.sv | 20 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default widths,
// FSM state encoding and port identifiers.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a conflict is
// resolved in favour of the port named by the pointer.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = (pointer == PORT_CORE) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Zero-wait, one-access-per-cycle arbiter between the core and loader/debug
// ports onto a single synchronous data memory with 1-cycle completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        grant_raw;
  logic [1:0]        grant;
  logic              ptr_q, ptr_d;
  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  rr_arbiter2 u_rr (
    .req     ({req1, req0}),
    .pointer (ptr_q),
    .grant   (grant_raw)
  );

  // Grants are combinational, so they must be gated to stay low during reset.
  assign grant = grant_raw & {2{reset}};

  always_comb begin
    ptr_d     = ptr_q;
    state_d   = state_q;
    port_d    = port_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt0      = grant[0];
    gnt1      = grant[1];
    mem_en    = |grant;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;

    case (state_q)
      IDLE:  if (|grant)  state_d = ISSUE;
      ISSUE: if (~|grant) state_d = IDLE;
    endcase

    if (grant[0]) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      ptr_d     = PORT_AUX;
      port_d    = PORT_CORE;
    end else if (grant[1]) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
      ptr_d     = PORT_CORE;
      port_d    = PORT_AUX;
    end

    if (|grant) begin
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      rd_d    = ~mem_we;
    end

    rvalid0 = (state_q == ISSUE) && (port_q == PORT_CORE);
    rvalid1 = (state_q == ISSUE) && (port_q == PORT_AUX);
    busy    = (state_q == ISSUE);
    // Read data passes straight through in the completion cycle, then holds.
    rdata   = ((state_q == ISSUE) && rd_q) ? mem_rdata : rdata_q;
    rdata_d = rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= PORT_CORE;
      state_q <= IDLE;
      port_q  <= PORT_CORE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
      port_q  <= port_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] mem_rdata_r = '0;
  assign mem_rdata = mem_rdata_r;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata_r   <= mem[mem_addr];
    end
  end

  typedef struct {
    int          due;
    bit          port;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_mem [1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          ptr_m = 1'b0;
  bit          exp_g0, exp_g1;
  logic [31:0] rdata_m = '0;
  logic [9:0]  last_addr_m = '0;
  logic [31:0] last_wdata_m = '0;

  // Completion monitor: sampled 4 time units after each rising edge.
  always begin
    exp_t e;
    bit   ev0, ev1;
    @(posedge clk);
    cyc++;
    #4;
    if (reset) begin
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        if (e.port) ev1 = 1'b1; else ev0 = 1'b1;
        if (e.rd) rdata_m = e.data;
      end
      checks++;
      if (rvalid0 !== ev0 || rvalid1 !== ev1) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got=%b%b exp=%b%b", cyc, rvalid1, rvalid0, ev1, ev0);
      end
      checks++;
      if (rdata !== rdata_m) begin
        errors++;
        $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, rdata_m);
      end
      checks++;
      if (busy !== (ev0 | ev1)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ev0 | ev1);
      end
    end
  end

  // Drives one cycle of requests, predicts the grant and queues the completion.
  task automatic drive_cycle(input bit r0, input bit w0, input logic [9:0] a0, input logic [31:0] d0,
                             input bit r1, input bit w1, input logic [9:0] a1, input logic [31:0] d1);
    exp_t e;
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #3;
    exp_g0 = r0 && (!r1 || ptr_m == 1'b0);
    exp_g1 = r1 && (!r0 || ptr_m == 1'b1);
    if (exp_g0 || exp_g1) begin
      e.due  = cyc + 1;
      e.port = exp_g1;
      e.rd   = exp_g0 ? !w0 : !w1;
      last_addr_m  = exp_g0 ? a0 : a1;
      last_wdata_m = exp_g0 ? d0 : d1;
      e.data = exp_mem[last_addr_m];
      if (!e.rd) exp_mem[last_addr_m] = last_wdata_m;
      sb.push_back(e);
      ptr_m = exp_g0;
    end
  endtask

  task automatic flush_model();
    sb.delete();
    ptr_m = 1'b0;
    rdata_m = '0;
    last_addr_m = '0;
    last_wdata_m = '0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    req0 = 1'b1; addr0 = 10'h155; wdata0 = 32'hA5A5A5A5; we0 = 1'b1; req1 = 1'b1;
    #2;
    checks++;
    if ({gnt1, gnt0, mem_en, mem_we, busy, rvalid1, rvalid0} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL in_reset gnt=%b%b en=%b we=%b busy=%b addr=%h wd=%h rd=%h",
               gnt1, gnt0, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata);
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
      checks++;
      if ({gnt1, gnt0, mem_en, mem_we, busy, rvalid1, rvalid0} !== 7'b0 ||
          mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
        errors++;
        $display("FAIL idle_after_reset i=%0d gnt=%b%b en=%b busy=%b addr=%h rd=%h",
                 i, gnt1, gnt0, mem_en, busy, mem_addr, rdata);
      end
    end
  endtask

  task automatic test_single_read();
    drive_cycle(1, 1, 10'h005, 32'hDEADBEEF, 0, 0, '0, '0);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'h005) begin
      errors++;
      $display("FAIL preload_write gnt=%b%b we=%b addr=%h", gnt1, gnt0, mem_we, mem_addr);
    end
    drive_cycle(1, 0, 10'h005, '0, 0, 0, '0, '0);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h005) begin
      errors++;
      $display("FAIL read_issue gnt=%b%b en=%b we=%b addr=%h", gnt1, gnt0, mem_en, mem_we, mem_addr);
    end
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_complete rv=%b%b rdata=%h exp=deadbeef", rvalid1, rvalid0, rdata);
    end
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h005 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hold_after_read en=%b we=%b addr=%h rdata=%h", mem_en, mem_we, mem_addr, rdata);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1 reset = 1'b1;
    flush_model();
  endtask

  task automatic test_alternate();
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1, 0, 10'h005, '0, 1, 0, 10'h005, '0);
      checks++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL alternate i=%0d got=%b%b", i, gnt1, gnt0);
      end
    end
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_write_read();
    drive_cycle(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h12345678);
    checks++;
    if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_issue gnt1=%b we=%b wd=%h", gnt1, mem_we, mem_wdata);
    end
    drive_cycle(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
    checks++;
    if (gnt0 !== 1'b1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL rd_after_wr gnt0=%b rvalid1=%b", gnt0, rvalid1);
    end
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    checks++;
    if (rvalid0 !== 1'b1 || rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_rd_data rvalid0=%b rdata=%h exp=12345678", rvalid0, rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      drive_cycle(0, 0, '0, '0, 1, 1, 10'(10'h010 + i), $urandom);
    for (int i = 0; i < 60; i++) begin
      bit r0, r1, w0, w1;
      logic [9:0] a0, a1;
      logic [31:0] d0, d1;
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = 10'(10'h010 + $urandom_range(0, 7)); a1 = 10'(10'h010 + $urandom_range(0, 7));
      d0 = $urandom; d1 = $urandom;
      drive_cycle(r0, w0, a0, d0, r1, w1, a1, d1);
      checks++;
      if (gnt0 !== exp_g0 || gnt1 !== exp_g1 || mem_en !== (exp_g0 | exp_g1)) begin
        errors++;
        $display("FAIL b2b_grant i=%0d got=%b%b exp=%b%b en=%b", i, gnt1, gnt0, exp_g1, exp_g0, mem_en);
      end
      checks++;
      if (mem_addr !== last_addr_m || mem_wdata !== last_wdata_m ||
          mem_we !== (exp_g0 ? w0 : (exp_g1 ? w1 : 1'b0))) begin
        errors++;
        $display("FAIL b2b_mem i=%0d addr=%h exp=%h wd=%h exp=%h we=%b",
                 i, mem_addr, last_addr_m, mem_wdata, last_wdata_m, mem_we);
      end
    end
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset_mid_access(input bit both);
    exp_t e;
    drive_cycle(1, 0, 10'h005, '0, 0, 0, '0, '0);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_grant both=%0d gnt0=%b", both, gnt0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || busy !== 1'b0 || rdata !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL mid_rst_outputs rv=%b%b busy=%b rdata=%h addr=%h", rvalid1, rvalid0, busy, rdata, mem_addr);
    end
    #1 reset = 1'b1;
    flush_model();
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005;
    req0 = both; we0 = 1'b0; addr0 = 10'h005;
    #1;
    checks++;
    if (gnt0 !== both || gnt1 !== !both) begin
      errors++;
      $display("FAIL post_rst_grant both=%0d got=%b%b", both, gnt1, gnt0);
    end
    e.due = cyc + 1; e.port = !both; e.rd = 1'b1; e.data = exp_mem[5];
    sb.push_back(e);
    ptr_m = both;
    last_addr_m = 10'h005;
    last_wdata_m = both ? wdata0 : wdata1;
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
    drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_back_to_back();
    test_reset_mid_access(1'b0);
    test_reset_mid_access(1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
